// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use / misprediction / memory-busy pipeline controller.
// Sits between IF/ID and ID/EX and drives PC and IF/ID enables, bubble
// select, IF/ID flush and a whole-pipeline hold.
// Optional feature macro: HAZARD_PERF_CNT_EN adds saturating stall/flush
// cycle counters on the stall_cycles / flush_cycles ports.
module hazard_stall_ctrl #(
  parameter int REG_AW          = 5,
  parameter int LOAD_USE_STALLS = 1,
  parameter int FLUSH_CYCLES    = 1,
  parameter int CNT_W           = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] if_id_rs1,
  input  logic [REG_AW-1:0] if_id_rs2,
  input  logic              if_id_use_rs1,
  input  logic              if_id_use_rs2,
  input  logic [REG_AW-1:0] id_ex_rd,
  input  logic              id_ex_mem_read,
  input  logic              wrong_prediction,
  input  logic              mem_busy,
  output logic              pc_write_en,
  output logic              if_id_write_en,
  output logic              ctrl_select,
  output logic              if_id_flush,
`ifdef HAZARD_PERF_CNT_EN
  output logic              pipe_hold,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_cycles
`else
  output logic              pipe_hold
`endif
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [3:0] StallReload = 4'(LOAD_USE_STALLS - 1);
  localparam logic [3:0] FlushReload = 4'(FLUSH_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       hazard;

  // Load-use hazard: EX holds a load whose non-zero destination is read by the decoding instruction.
  always_comb begin
    hazard = id_ex_mem_read && (id_ex_rd != '0) &&
             ((if_id_use_rs1 && (if_id_rs1 == id_ex_rd)) ||
              (if_id_use_rs2 && (if_id_rs2 == id_ex_rd)));
  end

  // Mealy output and next-state logic; priority is reset, misprediction, memory busy, then hazard/state.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pc_write_en    = 1'b1;
    if_id_write_en = 1'b1;
    ctrl_select    = 1'b1;
    if_id_flush    = 1'b0;
    pipe_hold      = 1'b0;
    if (rst) begin
      ctrl_select = 1'b0;
      if_id_flush = 1'b1;
      state_d     = RUN;
      cnt_d       = 4'd0;
    end else if (wrong_prediction) begin
      ctrl_select = 1'b0;
      if_id_flush = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d = FLUSH;
        cnt_d   = FlushReload;
      end else begin
        state_d = RUN;
        cnt_d   = 4'd0;
      end
    end else if (mem_busy) begin
      pipe_hold      = 1'b1;
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (hazard) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            ctrl_select    = 1'b0;
            if (LOAD_USE_STALLS > 1) begin
              state_d = STALL;
              cnt_d   = StallReload;
            end
          end
        end
        STALL: begin
          pc_write_en    = 1'b0;
          if_id_write_en = 1'b0;
          ctrl_select    = 1'b0;
          cnt_d          = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = RUN;
          end
        end
        FLUSH: begin
          ctrl_select = 1'b0;
          if_id_flush = 1'b1;
          cnt_d       = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  // State and remaining-cycle counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_cycles_q, flush_cycles_d;

  // Saturating counts of bubble cycles and squash cycles outside reset.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_cycles_d = flush_cycles_q;
    if (rst) begin
      stall_cycles_d = '0;
      flush_cycles_d = '0;
    end else begin
      if (!ctrl_select && !pc_write_en && (stall_cycles_q != '1)) begin
        stall_cycles_d = stall_cycles_q + 1'b1;
      end
      if (if_id_flush && (flush_cycles_q != '1)) begin
        flush_cycles_d = flush_cycles_q + 1'b1;
      end
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_cycles_q <= flush_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_cycles = flush_cycles_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed bench for hazard_stall_ctrl.
// Two instances share the inputs: dut_a (2 load-use stalls) and dut_b
// (3 load-use stalls); both use 3 flush cycles.
module tb_hazard_stall_ctrl;

`ifdef HAZARD_PERF_CNT_EN
  localparam int CW = 4;
`else
  localparam int CW = 16;
`endif

  // Output vector order: {pc_write_en, if_id_write_en, ctrl_select, if_id_flush, pipe_hold}
  localparam logic [4:0] V_RESET = 5'b11010;
  localparam logic [4:0] V_NORM  = 5'b11100;
  localparam logic [4:0] V_STALL = 5'b00000;
  localparam logic [4:0] V_FLUSH = 5'b11010;
  localparam logic [4:0] V_HOLD  = 5'b00101;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] if_id_rs1, if_id_rs2, id_ex_rd;
  logic       if_id_use_rs1, if_id_use_rs2, id_ex_mem_read;
  logic       wrong_prediction, mem_busy;
  logic       a_pc, a_ifid, a_ctrl, a_flush, a_hold;
  logic       b_pc, b_ifid, b_ctrl, b_flush, b_hold;
  logic [CW-1:0] a_stall_cnt, a_flush_cnt, b_stall_cnt, b_flush_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instance with two bubble cycles per load-use hazard.
  hazard_stall_ctrl #(.REG_AW(5), .LOAD_USE_STALLS(2), .FLUSH_CYCLES(3), .CNT_W(CW)) dut_a (
    .clk(clk), .rst(rst),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
    .if_id_use_rs1(if_id_use_rs1), .if_id_use_rs2(if_id_use_rs2),
    .id_ex_rd(id_ex_rd), .id_ex_mem_read(id_ex_mem_read),
    .wrong_prediction(wrong_prediction), .mem_busy(mem_busy),
    .pc_write_en(a_pc), .if_id_write_en(a_ifid), .ctrl_select(a_ctrl),
    .if_id_flush(a_flush),
`ifdef HAZARD_PERF_CNT_EN
    .pipe_hold(a_hold), .stall_cycles(a_stall_cnt), .flush_cycles(a_flush_cnt)
`else
    .pipe_hold(a_hold)
`endif
  );

  // Instance with three bubble cycles per load-use hazard.
  hazard_stall_ctrl #(.REG_AW(5), .LOAD_USE_STALLS(3), .FLUSH_CYCLES(3), .CNT_W(CW)) dut_b (
    .clk(clk), .rst(rst),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
    .if_id_use_rs1(if_id_use_rs1), .if_id_use_rs2(if_id_use_rs2),
    .id_ex_rd(id_ex_rd), .id_ex_mem_read(id_ex_mem_read),
    .wrong_prediction(wrong_prediction), .mem_busy(mem_busy),
    .pc_write_en(b_pc), .if_id_write_en(b_ifid), .ctrl_select(b_ctrl),
    .if_id_flush(b_flush),
`ifdef HAZARD_PERF_CNT_EN
    .pipe_hold(b_hold), .stall_cycles(b_stall_cnt), .flush_cycles(b_flush_cnt)
`else
    .pipe_hold(b_hold)
`endif
  );

`ifndef HAZARD_PERF_CNT_EN
  assign a_stall_cnt = '0;
  assign a_flush_cnt = '0;
  assign b_stall_cnt = '0;
  assign b_flush_cnt = '0;
`endif

  // Drives one complete input vector.
  task automatic applyStimulus(input logic r, input logic mr, input logic [4:0] rd,
                               input logic u1, input logic [4:0] r1,
                               input logic u2, input logic [4:0] r2,
                               input logic wp, input logic mb);
    rst = r; id_ex_mem_read = mr; id_ex_rd = rd;
    if_id_use_rs1 = u1; if_id_rs1 = r1;
    if_id_use_rs2 = u2; if_id_rs2 = r2;
    wrong_prediction = wp; mem_busy = mb;
    #1;
  endtask

  // Compares one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  function automatic logic [15:0] vecA();
    return {11'd0, a_pc, a_ifid, a_ctrl, a_flush, a_hold};
  endfunction

  function automatic logic [15:0] vecB();
    return {11'd0, b_pc, b_ifid, b_ctrl, b_flush, b_hold};
  endfunction

  // Moves to the next cycle: inputs change on the falling edge.
  task automatic nextCycle();
    @(negedge clk);
  endtask

  // Directed sequence: each step sets inputs then checks the combinational response.
  initial begin
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("reset_a", vecA(), {11'd0, V_RESET});
    checkOutput("reset_b", vecB(), {11'd0, V_RESET});
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("idle_a", vecA(), {11'd0, V_NORM});

    // Load-use through rs2: dut_a stalls 2 cycles, dut_b 3.
    applyStimulus(0, 1, 5, 0, 0, 1, 5, 0, 0);
    checkOutput("lu_c0_a", vecA(), {11'd0, V_STALL});
    checkOutput("lu_c0_b", vecB(), {11'd0, V_STALL});
    nextCycle();
    applyStimulus(0, 0, 5, 0, 0, 1, 5, 0, 0);
    checkOutput("lu_c1_a", vecA(), {11'd0, V_STALL});
    checkOutput("lu_c1_b", vecB(), {11'd0, V_STALL});
    nextCycle();
    applyStimulus(0, 0, 5, 0, 0, 1, 5, 0, 0);
    checkOutput("lu_c2_a", vecA(), {11'd0, V_NORM});
    checkOutput("lu_c2_b", vecB(), {11'd0, V_STALL});
    nextCycle();
    applyStimulus(0, 0, 5, 0, 0, 1, 5, 0, 0);
    checkOutput("lu_c3_b", vecB(), {11'd0, V_NORM});

    // Qualification: rs2 not used, or destination x0, means no hazard.
    applyStimulus(0, 1, 5, 0, 0, 0, 5, 0, 0);
    checkOutput("nouse_a", vecA(), {11'd0, V_NORM});
    applyStimulus(0, 1, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("rdzero_a", vecA(), {11'd0, V_NORM});
    applyStimulus(0, 1, 7, 1, 7, 0, 7, 0, 0);
    checkOutput("rs1_a", vecA(), {11'd0, V_STALL});
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    end
    checkOutput("rs1_drain_b", vecB(), {11'd0, V_NORM});

    // Single misprediction: three squash cycles.
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("fl_c0_a", vecA(), {11'd0, V_FLUSH});
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("fl_c1_a", vecA(), {11'd0, V_FLUSH});
    nextCycle();
    checkOutput("fl_c2_a", vecA(), {11'd0, V_FLUSH});
    nextCycle();
    checkOutput("fl_c3_a", vecA(), {11'd0, V_NORM});

    // Second misprediction in the second squash cycle restarts the window.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("fl2_c1_a", vecA(), {11'd0, V_FLUSH});
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("fl2_c2_a", vecA(), {11'd0, V_FLUSH});
    nextCycle();
    checkOutput("fl2_c3_a", vecA(), {11'd0, V_FLUSH});
    nextCycle();
    checkOutput("fl2_c4_a", vecA(), {11'd0, V_NORM});

    // Memory busy for 4 cycles during the second stall cycle of dut_b.
    applyStimulus(0, 1, 5, 0, 0, 1, 5, 0, 0);
    checkOutput("mb_c0_b", vecB(), {11'd0, V_STALL});
    for (int i = 1; i <= 4; i++) begin
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
      checkOutput($sformatf("mb_hold%0d_b", i), vecB(), {11'd0, V_HOLD});
    end
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("mb_c5_b", vecB(), {11'd0, V_STALL});
    checkOutput("mb_c5_a", vecA(), {11'd0, V_STALL});
    nextCycle();
    checkOutput("mb_c6_b", vecB(), {11'd0, V_STALL});
    checkOutput("mb_c6_a", vecA(), {11'd0, V_NORM});
    nextCycle();
    checkOutput("mb_c7_b", vecB(), {11'd0, V_NORM});

    // Hazard together with misprediction: flush wins, no stall follows.
    applyStimulus(0, 1, 5, 0, 0, 1, 5, 1, 0);
    checkOutput("hzwp_c0_b", vecB(), {11'd0, V_FLUSH});
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("hzwp_c1_b", vecB(), {11'd0, V_FLUSH});
    nextCycle();
    checkOutput("hzwp_c2_b", vecB(), {11'd0, V_FLUSH});
    nextCycle();
    checkOutput("hzwp_c3_b", vecB(), {11'd0, V_NORM});

    // Memory busy with a hazard in RUN: hold first, hazard re-evaluated afterwards.
    applyStimulus(0, 1, 5, 0, 0, 1, 5, 0, 1);
    checkOutput("mbhz_c0_b", vecB(), {11'd0, V_HOLD});
    nextCycle();
    applyStimulus(0, 1, 5, 0, 0, 1, 5, 0, 0);
    checkOutput("mbhz_c1_b", vecB(), {11'd0, V_STALL});

    // Reset in the middle of a stall returns to RUN.
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rststall_pre_b", vecB(), {11'd0, V_STALL});
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rststall_in_b", vecB(), {11'd0, V_RESET});
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rststall_post_b", vecB(), {11'd0, V_NORM});

`ifdef HAZARD_PERF_CNT_EN
    // Counters: cleared by reset, stall count saturates at 15 after 20 bubble cycles.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    applyStimulus(0, 1, 5, 0, 0, 1, 5, 0, 0);
    checkOutput("cnt_rst_stall_a", 16'(a_stall_cnt), 16'd0);
    checkOutput("cnt_rst_flush_a", 16'(a_flush_cnt), 16'd0);
    for (int i = 0; i < 20; i++) begin
      nextCycle();
    end
    checkOutput("cnt_sat_stall_a", 16'(a_stall_cnt), 16'd15);
    checkOutput("cnt_sat_stall_b", 16'(b_stall_cnt), 16'd15);
    checkOutput("cnt_sat_flush_a", 16'(a_flush_cnt), 16'd0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("cnt_clr_stall_a", 16'(a_stall_cnt), 16'd0);
    checkOutput("cnt_clr_flush_b", 16'(b_flush_cnt), 16'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
